// File: rtl/priority_encoder_pkg.sv
// Shared definitions for the pipelined priority encoder (leading-zero counter).
// Popcount classes are used only when PRIORITY_ENCODER_ONEHOT_CHECK_EN is defined.
package priority_encoder_pkg;

  localparam int GROUPS = 4;

  typedef enum logic [1:0] {
    PC_ZERO = 2'd0,
    PC_ONE  = 2'd1,
    PC_MANY = 2'd2
  } pc_class_e;

  // Index width that never collapses to zero for tiny words.
  function automatic int idx_width(input int bits);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < bits) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/priority_encoder_group.sv
// Combinational MSB-first find-first-one over one group of the input word.
// local_idx 0 refers to the group's most significant bit.
module priority_encoder_group #(
  parameter int GBITS = 8,
  parameter int LW    = $clog2(GBITS)
) (
  input  logic [GBITS-1:0] grp_data,
  output logic             found,
  output logic [LW-1:0]    local_idx
);

  always_comb begin
    found     = 1'b0;
    local_idx = '0;
    for (int i = 0; i < GBITS; i++) begin
      if (!found && grp_data[GBITS-1-i]) begin
        found     = 1'b1;
        local_idx = LW'(i);
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Two-stage priority encoder with valid/ready on both sides; index = BITS-1-p of highest set bit.
// Define PRIORITY_ENCODER_ONEHOT_CHECK_EN to drive out_err for inputs without exactly one bit set.
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int WIDTH = idx_width(BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BITS-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_index,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err
);

  localparam int GBITS = BITS / GROUPS;
  localparam int LW    = WIDTH - 2;

  typedef struct packed {
    logic [GROUPS-1:0]         found;
    logic [GROUPS-1:0][LW-1:0] lidx;
`ifdef PRIORITY_ENCODER_ONEHOT_CHECK_EN
    logic [GROUPS-1:0][1:0]    pc;
`endif
  } s1_t;

`ifdef PRIORITY_ENCODER_ONEHOT_CHECK_EN
  function automatic pc_class_e pc_class(input logic [GBITS-1:0] w);
    int n;
    n = 0;
    for (int i = 0; i < GBITS; i++) n += int'(w[i]);
    if (n == 0) return PC_ZERO;
    if (n == 1) return PC_ONE;
    return PC_MANY;
  endfunction
`endif

  logic [GROUPS-1:0]         grp_found;
  logic [GROUPS-1:0][LW-1:0] grp_lidx;

  s1_t              s1_new;
  s1_t              s1_p1_d, s1_p1_q;
  logic             vld_p1_d, vld_p1_q;
  logic             vld_p2_d, vld_p2_q;
  logic [WIDTH-1:0] idx_p2_d, idx_p2_q;
  logic             zero_p2_d, zero_p2_q;
  logic [1:0]       sel_g;

  logic s2_load;
  logic s1_adv;
  logic in_fire;

  assign s2_load  = !vld_p2_q || out_ready;
  assign s1_adv   = vld_p1_q && s2_load;
  assign in_ready = !rst && (!vld_p1_q || s2_load);
  assign in_fire  = in_valid && in_ready;

  // ---- Stage 1: per-group find-first-one; group 0 is the MSB group ----
  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    priority_encoder_group #(
      .GBITS(GBITS),
      .LW   (LW)
    ) u_grp (
      .grp_data (in_data[BITS-1-g*GBITS -: GBITS]),
      .found    (grp_found[g]),
      .local_idx(grp_lidx[g])
    );
  end

  always_comb begin
    s1_new       = '0;
    s1_new.found = grp_found;
    s1_new.lidx  = grp_lidx;
`ifdef PRIORITY_ENCODER_ONEHOT_CHECK_EN
    for (int g = 0; g < GROUPS; g++) begin
      s1_new.pc[g] = pc_class(in_data[BITS-1-g*GBITS -: GBITS]);
    end
`endif
    s1_p1_d  = in_fire ? s1_new : s1_p1_q;
    vld_p1_d = in_fire || (vld_p1_q && !s2_load);
  end

  always_ff @(posedge clk) begin
    s1_p1_q <= s1_p1_d;
  end

  // ---- Stage 2: pick the first group with a set bit ----
  always_comb begin
    sel_g = '0;
    for (int g = GROUPS - 1; g >= 0; g--) begin
      if (s1_p1_q.found[g]) sel_g = 2'(g);
    end
    vld_p2_d  = s2_load ? vld_p1_q : vld_p2_q;
    idx_p2_d  = s1_adv ? {sel_g, s1_p1_q.lidx[sel_g]} : idx_p2_q;
    zero_p2_d = s1_adv ? ~|s1_p1_q.found : zero_p2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      idx_p2_q  <= '0;
      zero_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      idx_p2_q  <= idx_p2_d;
      zero_p2_q <= zero_p2_d;
    end
  end

`ifdef PRIORITY_ENCODER_ONEHOT_CHECK_EN
  logic err_p2_d, err_p2_q;
  logic err_sel;

  // Exactly one set bit overall means exactly one PC_ONE group and no PC_MANY group.
  always_comb begin
    int ones;
    logic many;
    ones = 0;
    many = 1'b0;
    for (int g = 0; g < GROUPS; g++) begin
      if (pc_class_e'(s1_p1_q.pc[g]) == PC_ONE)  ones++;
      if (pc_class_e'(s1_p1_q.pc[g]) == PC_MANY) many = 1'b1;
    end
    err_sel  = many || (ones != 1);
    err_p2_d = s1_adv ? err_sel : err_p2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_p2_q <= 1'b0;
    end else begin
      err_p2_q <= err_p2_d;
    end
  end

  assign out_err = err_p2_q;
`else
  assign out_err = 1'b0;
`endif

  assign out_valid = vld_p2_q;
  assign out_index = idx_p2_q;
  assign out_zero  = zero_p2_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Directed and random checks for priority_encoder (BITS=32); honours PRIORITY_ENCODER_ONEHOT_CHECK_EN.
module tb_priority_encoder;

  localparam int BITS   = 32;
  localparam int WIDTH  = 5;
  localparam int NWORDS = 10000;

  logic             clk;
  logic             rst;
  logic [BITS-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_index;
  logic             out_zero;
  logic             out_valid;
  logic             out_ready;
  logic             out_err;

  int checks;
  int errors;

  priority_encoder #(.BITS(BITS), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_index(out_index),
    .out_zero (out_zero),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] ref_lzc(input logic [BITS-1:0] w);
    for (int i = BITS - 1; i >= 0; i--) begin
      if (w[i]) return WIDTH'(BITS - 1 - i);
    end
    return '0;
  endfunction

  function automatic logic ref_err(input logic [BITS-1:0] w);
`ifdef PRIORITY_ENCODER_ONEHOT_CHECK_EN
    return $countones(w) != 1;
`else
    return (w == w) ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_index !== 5'd0) begin errors++; $display("FAIL reset_out_index got %0d want 0", out_index); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %0b want 0", out_zero); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %0b want 0", out_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_latency();
    @(negedge clk); in_data = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early_valid got %0b want 0", out_valid); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %0b want 1", out_valid); end
    checks++; if (out_index !== 5'd0) begin errors++; $display("FAIL latency_index got %0d want 0", out_index); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL latency_zero got %0b want 0", out_zero); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_single_word got %0b want 0", out_valid); end
  endtask

  task automatic test_onehot_sweep();
    logic [BITS-1:0] exp_w;
    out_ready = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk); #1;
      if (c >= 2) begin
        exp_w = 32'h1 << (c - 2);
        checks++;
        if (out_valid !== 1'b1 || out_index !== WIDTH'(31 - (c - 2)) || out_zero !== 1'b0) begin
          errors++;
          $display("FAIL sweep_k%0d got v=%0b idx=%0d z=%0b want v=1 idx=%0d z=0",
                   c - 2, out_valid, out_index, out_zero, 31 - (c - 2));
        end
        checks++;
        if ((32'h8000_0000 >> out_index) !== exp_w) begin
          errors++;
          $display("FAIL sweep_decode_k%0d got %08h want %08h", c - 2, 32'h8000_0000 >> out_index, exp_w);
        end
        checks++;
        if (out_err !== 1'b0) begin errors++; $display("FAIL sweep_err_k%0d got %0b want 0", c - 2, out_err); end
      end
      if (c < 32) begin
        in_valid = 1'b1; in_data = 32'h1 << c;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_special_words();
    logic [BITS-1:0] words [4];
    logic [WIDTH-1:0] exp_idx [4];
    logic             exp_zero [4];
    words[0] = 32'h0000_0000; exp_idx[0] = 5'd0;  exp_zero[0] = 1'b1;
    words[1] = 32'h0000_0101; exp_idx[1] = 5'd23; exp_zero[1] = 1'b0;
    words[2] = 32'hFFFF_FFFF; exp_idx[2] = 5'd0;  exp_zero[2] = 1'b0;
    words[3] = 32'h0010_0000; exp_idx[3] = 5'd11; exp_zero[3] = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_index !== exp_idx[c-2] || out_zero !== exp_zero[c-2]) begin
          errors++;
          $display("FAIL special_%08h got v=%0b idx=%0d z=%0b want v=1 idx=%0d z=%0b",
                   words[c-2], out_valid, out_index, out_zero, exp_idx[c-2], exp_zero[c-2]);
        end
        checks++;
        if (out_err !== ref_err(words[c-2])) begin
          errors++;
          $display("FAIL special_err_%08h got %0b want %0b", words[c-2], out_err, ref_err(words[c-2]));
        end
      end
      if (c < 4) begin
        in_valid = 1'b1; in_data = words[c];
      end else begin
        in_valid = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0101; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_w0_ready got %0b want 1", in_ready); end
    @(negedge clk); in_data = 32'h0000_0000; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_w1_ready got %0b want 1", in_ready); end
    @(negedge clk); in_data = 32'h0004_0000; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %0b want 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if (out_valid !== 1'b1 || out_index !== 5'd23 || out_zero !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%0b idx=%0d z=%0b rdy=%0b want v=1 idx=23 z=0 rdy=0",
                 i, out_valid, out_index, out_zero, in_ready);
      end
    end
    @(negedge clk); out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_pop_push_ready got %0b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 5'd0 || out_zero !== 1'b1) begin
      errors++;
      $display("FAIL stall_second got v=%0b idx=%0d z=%0b want v=1 idx=0 z=1", out_valid, out_index, out_zero);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 5'd13 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL stall_third got v=%0b idx=%0d z=%0b want v=1 idx=13 z=0", out_valid, out_index, out_zero);
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [BITS-1:0] q [$];
    logic [BITS-1:0] w;
    logic [BITS-1:0] exp_w;
    logic            pend;
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; pend = 1'b0; w = '0;
    while (rcvd < NWORDS && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!pend && sent < NWORDS && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: w = 32'h1 << $urandom_range(0, 31);
          1: w = $urandom >> $urandom_range(0, 32);
          2: w = ($urandom & $urandom) >> $urandom_range(0, 31);
          default: w = $urandom;
        endcase
        pend = 1'b1;
      end
      in_valid  = pend;
      in_data   = pend ? w : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL random_spurious got idx=%0d want no output", out_index);
        end else begin
          exp_w = q.pop_front();
          rcvd++;
          if (out_index !== ref_lzc(exp_w) || out_zero !== (exp_w == 0) || out_err !== ref_err(exp_w)) begin
            errors++;
            $display("FAIL random_word_%08h got idx=%0d z=%0b e=%0b want idx=%0d z=%0b e=%0b",
                     exp_w, out_index, out_zero, out_err, ref_lzc(exp_w), exp_w == 0, ref_err(exp_w));
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(w);
        pend = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (rcvd != NWORDS || q.size() != 0) begin
      errors++;
      $display("FAIL random_count got %0d received (%0d queued) want %0d", rcvd, q.size(), NWORDS);
    end
    @(negedge clk); out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0001;
    @(negedge clk); in_data = 32'h0000_0002;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %0b want 1", out_valid); end
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %0b want 0", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ghost_%0d got %0b want 0", i, out_valid); end
    end
    @(negedge clk); in_valid = 1'b1; in_data = 32'h0000_0010;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 5'd27 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next got v=%0b idx=%0d z=%0b want v=1 idx=27 z=0", out_valid, out_index, out_zero);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_onehot_sweep();
    test_special_words();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
